// File: rtl/interfaz_adc_muestreo.sv
// Serial 12-bit ADC front end: timed CS_n/SCLK conversions, offset-binary to signed Q format.
// Emits a one-cycle Bandera_ADC strobe with each new Uk and flags dropped sample ticks.
module interfaz_adc_muestreo #(
  parameter int unsigned N       = 25,
  parameter int unsigned F       = 15,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned FS_DIV  = 10000
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Enable,
  input  logic                SDATA,
  output logic                CS_n,
  output logic                SCLK,
  output logic signed [N-1:0] Uk,
  output logic                Bandera_ADC,
  output logic                Overrun_ADC
);

  localparam int unsigned TW = $clog2(FS_DIV + 1);
  localparam int unsigned HW = $clog2(CLK_DIV + 1);
  localparam int unsigned SH = F - 11;

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e             r_state;
  logic [TW-1:0]      r_cnt;
  logic [HW-1:0]      r_half;
  logic [5:0]         r_phase;
  logic [15:0]        r_shift;
  logic               r_cs_n;
  logic               r_sclk;
  logic               r_bandera;
  logic               r_overrun;
  logic signed [N-1:0] r_uk;

  logic               w_tick;
  logic               w_half_end;
  logic signed [11:0] w_s;
  logic signed [N-1:0] w_uk;
  logic               w_unused;

  assign w_tick     = Enable && (r_cnt == TW'(FS_DIV - 1));
  assign w_half_end = (r_half == HW'(CLK_DIV - 1));

  // code - 2048 is the code with its MSB inverted, read as 12-bit two's complement
  assign w_s      = {~r_shift[11], r_shift[10:0]};
  assign w_uk     = {{(N - 12){w_s[11]}}, w_s} << SH;
  assign w_unused = ^r_shift[15:12];

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_cnt <= '0;
    end else if (!Enable || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Phase 0 is the CS_n-to-SCLK setup; odd phases are SCLK low, even phases SCLK high.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state   <= StIdle;
      r_half    <= '0;
      r_phase   <= '0;
      r_shift   <= '0;
      r_cs_n    <= 1'b1;
      r_sclk    <= 1'b1;
      r_bandera <= 1'b0;
      r_overrun <= 1'b0;
      r_uk      <= '0;
    end else begin
      r_bandera <= 1'b0;
      if (w_tick && (r_state != StIdle)) begin
        r_overrun <= 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (w_tick) begin
            r_state <= StConv;
            r_cs_n  <= 1'b0;
            r_sclk  <= 1'b1;
            r_half  <= '0;
            r_phase <= '0;
          end
        end
        StConv: begin
          if (w_half_end && r_phase[0]) begin
            r_shift <= {r_shift[14:0], SDATA};
          end
          if (w_half_end) begin
            r_half <= '0;
            if (r_phase == 6'd32) begin
              r_state   <= StDone;
              r_cs_n    <= 1'b1;
              r_sclk    <= 1'b1;
              r_bandera <= 1'b1;
              r_uk      <= w_uk;
            end else begin
              r_phase <= r_phase + 6'd1;
              r_sclk  <= r_phase[0];
            end
          end else begin
            r_half <= r_half + 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign CS_n        = r_cs_n;
  assign SCLK        = r_sclk;
  assign Uk          = r_uk;
  assign Bandera_ADC = r_bandera;
  assign Overrun_ADC = r_overrun;

endmodule

// File: tb/tb_interfaz_adc_muestreo.sv
// Directed bench: ADC serial models feed a default instance and a fast-tick overrun instance.
module tb_interfaz_adc_muestreo;

  localparam int unsigned N = 25;

  logic         Clk;
  logic         Reset_n;
  logic         rst2_n;
  logic         Enable;
  logic         SDATA;
  logic         sdata2;
  logic         cs_n;
  logic         sclk;
  logic         cs2_n;
  logic         sclk2;
  logic [N-1:0] uk;
  logic [N-1:0] uk2;
  logic         band;
  logic         band2;
  logic         ovr;
  logic         ovr2;

  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  int           prev_strobe = -1;
  int           last_low = 0;
  bit           sel = 1'b0;

  logic [15:0]  word1 = 16'h0800;
  logic [15:0]  word2 = 16'h0800;
  int           idx1 = 15;
  int           idx2 = 15;

  interfaz_adc_muestreo #(
    .N(25), .F(15), .CLK_DIV(4), .FS_DIV(10000)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Enable(Enable), .SDATA(SDATA),
    .CS_n(cs_n), .SCLK(sclk), .Uk(uk), .Bandera_ADC(band), .Overrun_ADC(ovr)
  );

  interfaz_adc_muestreo #(
    .N(25), .F(15), .CLK_DIV(4), .FS_DIV(100)
  ) dut_ov (
    .Clk(Clk), .Reset_n(rst2_n), .Enable(Enable), .SDATA(sdata2),
    .CS_n(cs2_n), .SCLK(sclk2), .Uk(uk2), .Bandera_ADC(band2), .Overrun_ADC(ovr2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  // ADC models: new bit after each SCLK fall, MSB first, restarting at each CS_n fall.
  always @(negedge cs_n) idx1 = 15;
  always @(negedge sclk) SDATA = word1[idx1[3:0]];
  always @(posedge sclk) if (!cs_n && idx1 > 0) idx1--;
  always @(negedge cs2_n) idx2 = 15;
  always @(negedge sclk2) sdata2 = word2[idx2[3:0]];
  always @(posedge sclk2) if (!cs2_n && idx2 > 0) idx2--;

  logic         m_cs, m_sclk, m_band, m_ovr;
  logic [N-1:0] m_uk;
  assign m_cs   = sel ? cs2_n : cs_n;
  assign m_sclk = sel ? sclk2 : sclk;
  assign m_band = sel ? band2 : band;
  assign m_ovr  = sel ? ovr2 : ovr;
  assign m_uk   = sel ? uk2 : uk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full conversion on the selected instance, from waiting for CS_n to the strobe after.
  task automatic sample(input string tag, input logic [15:0] w, input logic [N-1:0] exp_uk,
                        input logic exp_ovr0, input logic exp_ovr1, input int exp_period);
    int n, t_str, cs_cnt, rises;
    logic prev;
    bit seen;
    if (sel) word2 = w;
    else word1 = w;
    n = 0;
    while (m_cs && n < 10100) begin
      @(negedge Clk);
      n++;
    end
    if (m_cs) begin
      check_eq({tag, "_cs_timeout"}, 32'(m_cs), 32'd0);
      return;
    end
    last_low = cyc;
    check_eq({tag, "_ovr_start"}, 32'(m_ovr), 32'(exp_ovr0));
    cs_cnt = 0;
    rises  = 0;
    prev   = m_sclk;
    seen   = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (m_band) begin
        seen = 1'b1;
      end else begin
        if (!m_cs) cs_cnt++;
        if (m_sclk && !prev) rises++;
        prev = m_sclk;
        @(negedge Clk);
      end
    end
    check_eq({tag, "_strobe"}, 32'(seen), 32'd1);
    t_str = cyc;
    check_eq({tag, "_latency"}, 32'(t_str - last_low + 1), 32'd133);
    check_eq({tag, "_cs_low"}, 32'(cs_cnt), 32'd132);
    check_eq({tag, "_sclk_rises"}, 32'(rises), 32'd16);
    check_eq({tag, "_uk"}, 32'(m_uk), 32'(exp_uk));
    check_eq({tag, "_ovr"}, 32'(m_ovr), 32'(exp_ovr1));
    if (prev_strobe >= 0) check_eq({tag, "_period"}, 32'(t_str - prev_strobe), 32'(exp_period));
    prev_strobe = t_str;
    @(negedge Clk);
    check_eq({tag, "_band_1cyc"}, 32'(m_band), 32'd0);
    check_eq({tag, "_uk_hold"}, 32'(m_uk), 32'(exp_uk));
  endtask

  initial begin
    int c0, n, rises, nb;
    logic prev;
    Reset_n = 1'b0;
    rst2_n  = 1'b0;
    Enable  = 1'b1;
    SDATA   = 1'b1;
    sdata2  = 1'b1;
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    check_eq("rst_uk", 32'(uk), 32'd0);
    check_eq("rst_band", 32'(band), 32'd0);
    check_eq("rst_cs_n", 32'(cs_n), 32'd1);
    check_eq("rst_sclk", 32'(sclk), 32'd1);
    check_eq("rst_ovr", 32'(ovr), 32'd0);
    Reset_n = 1'b1;
    c0 = cyc;

    sample("mid", 16'h0800, 25'h0000000, 1'b0, 1'b0, 10000);
    check_eq("first_tick", 32'(last_low - c0), 32'd10000);
    sample("max", 16'h0FFF, 25'h0007FF0, 1'b0, 1'b0, 10000);
    sample("min", 16'h0000, 25'h1FF8000, 1'b0, 1'b0, 10000);
    sample("p123", 16'h0123, 25'h1FF9230, 1'b0, 1'b0, 10000);
    sample("pA5A", 16'h5A5A, 25'h00025A0, 1'b0, 1'b0, 10000);
    sample("p7FF", 16'h07FF, 25'h1FFFFF0, 1'b0, 1'b0, 10000);

    // Abort a conversion right after the eighth SCLK rising edge.
    word1 = 16'h0FFF;
    n = 0;
    while (cs_n && n < 10100) begin
      @(negedge Clk);
      n++;
    end
    check_eq("abort_cs_started", 32'(cs_n), 32'd0);
    rises = 0;
    prev  = sclk;
    n     = 0;
    while (rises < 8 && n < 200) begin
      @(negedge Clk);
      if (sclk && !prev) rises++;
      prev = sclk;
      n++;
    end
    check_eq("abort_rises", 32'(rises), 32'd8);
    Reset_n = 1'b0;
    @(negedge Clk);
    check_eq("abort_cs_n", 32'(cs_n), 32'd1);
    check_eq("abort_sclk", 32'(sclk), 32'd1);
    check_eq("abort_uk", 32'(uk), 32'd0);
    Reset_n = 1'b1;
    nb = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (band) nb++;
    end
    check_eq("abort_no_band", 32'(nb), 32'd0);
    check_eq("abort_uk_after", 32'(uk), 32'd0);

    // Fast-tick instance: tick at 199 lands inside the first conversion.
    sel = 1'b1;
    prev_strobe = -1;
    @(negedge Clk);
    rst2_n = 1'b1;
    c0 = cyc;
    sample("ov1", 16'h0800, 25'h0000000, 1'b0, 1'b1, 200);
    check_eq("ov_first_tick", 32'(last_low - c0), 32'd100);
    sample("ov2", 16'h0FFF, 25'h0007FF0, 1'b1, 1'b1, 200);
    check_eq("ov_second_start", 32'(last_low - c0), 32'd300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/interfaz_adc_muestreo.md
Name:
interfaz_adc_muestreo

Overview:
- Front-end stage that drives an external serial 12-bit ADC (ADC121S101-class: CS_n, SCLK, SDATA) at a fixed sample rate.
- Converts each offset-binary code into signed fixed-point Uk and emits a one-cycle Bandera_ADC strobe.
- Feeds the 200 Hz low-pass filter's Uk / Bandera_ADC inputs directly.
- One Clk domain. Reset is synchronous and active-low.

Parameters:
- N, 25: width of Uk, signed two's complement.
- F, 15: fractional bits of Uk. Must satisfy 11 <= F <= N-2.
- CLK_DIV, 4: SCLK half-period in Clk cycles (>= 1).
- FS_DIV, 10000: sample period in Clk cycles. Must be > 33*CLK_DIV+2.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset_n  in  1  synchronous active-low reset.
- Enable  in  1  1 = sample timer runs.
- SDATA  in  1  ADC serial data, MSB first.
- CS_n  out  1  ADC chip select, active low.
- SCLK  out  1  ADC serial clock, idles high.
- Uk  out  N  latest sample, signed Q(N-F-1).F.
- Bandera_ADC  out  1  one-Clk strobe: Uk is updated.
- Overrun_ADC  out  1  sticky: a sample tick was missed.

Behaviour:
- Reset (Reset_n=0 at a rising edge):
  - Uk=0, Bandera_ADC=0, CS_n=1, SCLK=1, Overrun_ADC=0.
  - Timer=0, state=IDLE, shift register=0.
  - Reset aborts any conversion in progress (CS_n returns high the next cycle, no strobe).
- Timer:
  - Counts 0..FS_DIV-1 while Enable=1, then wraps to 0.
  - tick=1 in the cycle count==FS_DIV-1.
  - Enable=0 holds timer at 0; a conversion already started still completes.
  - First tick occurs FS_DIV cycles after reset release with Enable=1.
- FSM states IDLE -> CONV -> DONE -> IDLE.
  - IDLE: CS_n=1, SCLK=1. tick -> CONV.
  - CONV entry (cycle after tick): CS_n=0; SCLK stays high for CLK_DIV cycles (setup).
  - CONV body: 16 SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high.
  - SDATA is shifted into a 16-bit register on the last Clk cycle of each low phase (the SCLK rising transition).
  - CONV total length is 33*CLK_DIV cycles, then -> DONE.
  - DONE (1 cycle): CS_n=1, SCLK=1, Bandera_ADC=1, Uk loaded. Then -> IDLE.
- Latency: tick at cycle t gives Bandera_ADC=1 and the new Uk at cycle t+1+33*CLK_DIV (t+133 with defaults).
- Output hold: Uk is held constant between strobes. Bandera_ADC is never high for 2 consecutive cycles.
- Conversion arithmetic:
  - code = word[11:0]; word[15:12] (leading zeros) is ignored.
  - s = code - 2048, 13-bit signed, range -2048..2047.
  - Uk = sign_extend_N(s) << (F-11), representing s/2048, range [-1.0, +1.0).
  - Exact; no rounding or saturation needed.
- Overrun: a tick while state != IDLE is dropped (no restart) and Overrun_ADC is set to 1 until reset.
- Simultaneous events:
  - Reset_n=0 dominates everything.
  - A tick coinciding with DONE counts as overrun.

Test Plan:
- Reset: hold Reset_n=0 for 5 cycles with SDATA=1 and Enable=1 -> Uk=0, Bandera_ADC=0, CS_n=1, SCLK=1; first tick appears 10000 cycles after release.
- Mid-scale: ADC model returns code 0x800 -> Uk=0, strobe exactly 133 cycles after tick, CS_n low for 132 cycles, 16 SCLK rising edges observed.
- Extremes:
  - code 0xFFF -> Uk = 2047<<4 = 0x0007FF0.
  - code 0x000 -> Uk = -2048<<4 = 0x1FF8000 (25-bit).
- Periodicity: Enable=1, run 3 samples with codes 0x123, 0xA5A, 0x7FF -> strobes 10000 cycles apart; Uk = -1757<<4, 602<<4, -1<<4 (= 0x1FFFFF0); no Overrun.
- Reset mid-CONV: assert Reset_n=0 at SCLK edge 8 -> CS_n=1 next cycle, no Bandera_ADC, Uk stays 0.
- Overrun: instance with FS_DIV=100, CLK_DIV=4 -> second tick lands during CONV; Overrun_ADC=1 and sticky; each conversion still completes with 133-cycle latency.
